gpio_ctrl: RTL and testbench
============================

GPIO_CTRL -- requirements
Module: gpio_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: number of GPIO bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: pin-state synchronizer depth, legal range 2..4.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port addr, input, 5: byte address, word-aligned; addr[1:0] ignored.
REQ-006 SHALL have port wdata, input, 32: write data; bits above WIDTH ignored.
REQ-007 SHALL have port we, input, 1: write strobe, one cycle.
REQ-008 SHALL have port re, input, 1: read strobe, one cycle.
REQ-009 SHALL have port rdata, output, 32: read data, zero-extended.
REQ-010 SHALL have port rvalid, output, 1: read-data-valid pulse.
REQ-011 SHALL have port err, output, 1: unmapped-access pulse.
REQ-012 SHALL have port gpio_dr, output, WIDTH: data register to the pad stage.
REQ-013 SHALL have port gpio_ts, output, WIDTH: per-bit drive enable to the pad stage; 1 means drive.
REQ-014 SHALL have port gpio_ps, input, WIDTH: asynchronous pin state from the pad stage.
REQ-015 SHALL have port irq, output, 1: level interrupt.

Function
REQ-016 SHALL map the registers as follows: DR 0x00 RW; TS 0x04 RW; PS 0x08 RO (synchronized pin state); IE 0x0C RW; POL 0x10 RW (1 = rising, 0 = falling); IS 0x14 W1C.
REQ-017 SHALL update a register on the clk edge where we=1; gpio_dr and gpio_ts SHALL reflect the write one cycle after the we edge.
REQ-018 SHALL assert rdata and rvalid one cycle after re; rdata SHALL hold its value and rvalid SHALL be 0 in every other cycle.
REQ-019 SHALL, when we and re are both 1, perform the write and return the pre-write value on the read.
REQ-020 SHALL, for we or re to an unmapped address or a write to PS, pulse err one cycle later, change no state, and return rdata=0 if reading.
REQ-021 SHALL pass gpio_ps through SYNC_STAGES flip-flops, then through one previous-value flop used for edge detection.
REQ-022 SHALL detect an edge on bit i when the synchronized value differs from the previous value in the polarity selected by POL[i], and then set IS[i].
REQ-023 SHALL, when a W1C to IS[i] coincides with a new edge on bit i, leave IS[i] set (set wins).
REQ-024 SHALL use a warm-up counter to suppress edge detection until SYNC_STAGES+1 cycles after reset deassertion, so that no edge is detected on a pin that is static high.
REQ-025 SHALL register irq as the OR of (IS & IE), so irq follows IS/IE by one cycle.
REQ-026 SHALL leave IS bits unchanged when IE changes; masking only affects irq.

Reset
REQ-027 SHALL, asynchronously on reset, clear DR, TS, IE, POL, IS, the synchronizer, the previous-value flop, the warm-up counter, rdata, rvalid, err and irq to 0; all pins are therefore undriven.
REQ-028 SHALL, when reset asserts during an access, discard the access and produce no rvalid or err pulse after release.

Configuration
REQ-029 SHALL compile the edge-detect and interrupt logic only when macro GPIO_CTRL_IRQ_EN is defined.
REQ-030 SHALL, without GPIO_CTRL_IRQ_EN, tie irq to 0, read IE, POL and IS as 0, ignore writes to them without err, and omit the previous-value flop and the warm-up counter.

Structure
REQ-031 SHALL take the register address constants, the register-index enumeration and the default WIDTH from the shared package gpio_pkg.
REQ-032 SHALL instantiate one sub-module, gpio_sync (parameterized width and depth), for the pin synchronizer.

Verification
REQ-033 SHALL cover: write DR=0x00A5, TS=0x00FF -> gpio_dr=0x00A5 and gpio_ts=0x00FF one cycle after each write.
REQ-034 SHALL cover: gpio_ps=0x1234 held, read PS after 3 cycles -> rdata=0x00001234 with rvalid one cycle after re.
REQ-035 SHALL cover: with IE=0x0001, POL=0x0001 and gpio_ps[0] rising -> IS=0x0001 and irq=1 within SYNC_STAGES+2 cycles; writing IS=0x0001 clears irq next cycle.
REQ-036 SHALL cover: W1C to IS[0] in the same cycle as a new rising edge on bit 0 -> IS[0] stays 1.
REQ-037 SHALL cover: read of addr 0x18 -> err pulse, rdata=0, no state change.
REQ-038 SHALL cover: gpio_ps=0xFFFF held through reset release -> IS remains 0x0000; reset asserted mid-read -> no rvalid after release.

Source files
------------

// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared register map, register index enum and defaults for gpio_ctrl
package gpio_pkg;

  // Default number of GPIO bits.
  localparam int GPIO_DEFAULT_WIDTH = 16;

  // Default pin-state synchronizer depth.
  localparam int GPIO_DEFAULT_SYNC_STAGES = 2;

  // Byte addresses of the register map.
  localparam logic [4:0] ADDR_DR  = 5'h00;
  localparam logic [4:0] ADDR_TS  = 5'h04;
  localparam logic [4:0] ADDR_PS  = 5'h08;
  localparam logic [4:0] ADDR_IE  = 5'h0C;
  localparam logic [4:0] ADDR_POL = 5'h10;
  localparam logic [4:0] ADDR_IS  = 5'h14;

  // Register index decoded from a byte address.
  typedef enum logic [2:0] {
    REG_DR       = 3'd0,
    REG_TS       = 3'd1,
    REG_PS       = 3'd2,
    REG_IE       = 3'd3,
    REG_POL      = 3'd4,
    REG_IS       = 3'd5,
    REG_UNMAPPED = 3'd6
  } reg_idx_e;

  // Word-align the address (low two bits dropped) and map it to a register index.
  function automatic reg_idx_e addr_to_idx(input logic [4:0] a);
    logic [4:0] word_addr;
    word_addr = a & 5'b11100;
    case (word_addr)
      ADDR_DR:  return REG_DR;
      ADDR_TS:  return REG_TS;
      ADDR_PS:  return REG_PS;
      ADDR_IE:  return REG_IE;
      ADDR_POL: return REG_POL;
      ADDR_IS:  return REG_IS;
      default:  return REG_UNMAPPED;
    endcase
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// rtl/gpio_sync.sv - multi-stage synchronizer for the asynchronous pin state
module gpio_sync
  import gpio_pkg::*;
#(
  parameter int WIDTH = GPIO_DEFAULT_WIDTH,
  parameter int DEPTH = GPIO_DEFAULT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Stage 0 samples the pins; the last stage is the synchronized value.
  logic [DEPTH-1:0][WIDTH-1:0] stage_q;

  // Shift the pin state through the flop chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[DEPTH-2:0], din};
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - GPIO register block with pin sync and optional edge interrupts (GPIO_CTRL_IRQ_EN)
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH       = GPIO_DEFAULT_WIDTH,
  parameter int SYNC_STAGES = GPIO_DEFAULT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       addr,
  input  logic [31:0]      wdata,
  input  logic             we,
  input  logic             re,
  output logic [31:0]      rdata,
  output logic             rvalid,
  output logic             err,
  output logic [WIDTH-1:0] gpio_dr,
  output logic [WIDTH-1:0] gpio_ts,
  input  logic [WIDTH-1:0] gpio_ps,
  output logic             irq
);

  reg_idx_e         idx;
  logic             acc_unmapped;
  logic             wr_bad;
  logic             wr_ok;
  logic             err_d;
  logic [31:0]      rd_word;
  logic [WIDTH-1:0] wr_val;
  logic [WIDTH-1:0] dr_q;
  logic [WIDTH-1:0] ts_q;
  logic [WIDTH-1:0] ps_sync;
  logic             unused_wdata;

  // Bits of wdata above WIDTH carry no meaning for this block.
  assign unused_wdata = ^wdata;

  assign idx          = addr_to_idx(addr);
  assign acc_unmapped = (idx == REG_UNMAPPED);
  // PS is read-only, so a write to it is treated like an unmapped access.
  assign wr_bad       = we && (acc_unmapped || (idx == REG_PS));
  assign wr_ok        = we && !wr_bad;
  assign err_d        = wr_bad || (re && acc_unmapped);
  assign wr_val       = wdata[WIDTH-1:0];

  gpio_sync #(
    .WIDTH (WIDTH),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (gpio_ps),
    .dout  (ps_sync)
  );

  // Pad-facing data and drive-enable registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dr_q <= '0;
      ts_q <= '0;
    end else if (wr_ok) begin
      if (idx == REG_DR) dr_q <= wr_val;
      if (idx == REG_TS) ts_q <= wr_val;
    end
  end

  assign gpio_dr = dr_q;
  assign gpio_ts = ts_q;

`ifdef GPIO_CTRL_IRQ_EN
  // Detection stays off until the synchronizer and previous-value flop hold real pin state.
  localparam int WARM_MAX = SYNC_STAGES + 1;
  localparam int CW       = $clog2(WARM_MAX + 1);

  logic [WIDTH-1:0] ie_q;
  logic [WIDTH-1:0] pol_q;
  logic [WIDTH-1:0] is_q;
  logic [WIDTH-1:0] prev_q;
  logic [CW-1:0]    warm_q;
  logic             warm_done;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] w1c_mask;
  logic             irq_q;

  assign warm_done = (warm_q == CW'(WARM_MAX));
  assign rise      = ps_sync & ~prev_q;
  assign fall      = ~ps_sync & prev_q;
  assign edge_hit  = warm_done ? ((rise & pol_q) | (fall & ~pol_q)) : '0;
  assign w1c_mask  = (wr_ok && (idx == REG_IS)) ? wr_val : '0;

  // Count up after reset release and saturate once detection is armed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_q <= '0;
    end else if (!warm_done) begin
      warm_q <= warm_q + CW'(1);
    end
  end

  // Previous synchronized pin value for edge comparison.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
    end else begin
      prev_q <= ps_sync;
    end
  end

  // Interrupt enable and polarity registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie_q  <= '0;
      pol_q <= '0;
    end else if (wr_ok) begin
      if (idx == REG_IE)  ie_q  <= wr_val;
      if (idx == REG_POL) pol_q <= wr_val;
    end
  end

  // Sticky status: write-one clears, a new edge in the same cycle keeps the bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_q <= '0;
    end else begin
      is_q <= (is_q & ~w1c_mask) | edge_hit;
    end
  end

  // Level interrupt registered from the masked status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(is_q & ie_q);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Read mux; unmapped addresses and disabled interrupt registers read as zero.
  always_comb begin
    rd_word = '0;
    case (idx)
      REG_DR:  rd_word[WIDTH-1:0] = dr_q;
      REG_TS:  rd_word[WIDTH-1:0] = ts_q;
      REG_PS:  rd_word[WIDTH-1:0] = ps_sync;
`ifdef GPIO_CTRL_IRQ_EN
      REG_IE:  rd_word[WIDTH-1:0] = ie_q;
      REG_POL: rd_word[WIDTH-1:0] = pol_q;
      REG_IS:  rd_word[WIDTH-1:0] = is_q;
`endif
      default: rd_word = '0;
    endcase
  end

  // Read response and error pulse; rdata holds between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      rvalid <= re;
      err    <= err_d;
      if (re) rdata <= rd_word;
    end
  end

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb/tb_gpio_ctrl.sv - directed self-checking bench for gpio_ctrl
module tb_gpio_ctrl;
  import gpio_pkg::*;

  localparam int WIDTH       = 16;
  localparam int SYNC_STAGES = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       addr;
  logic [31:0]      wdata;
  logic             we;
  logic             re;
  logic [31:0]      rdata;
  logic             rvalid;
  logic             err;
  logic [WIDTH-1:0] gpio_dr;
  logic [WIDTH-1:0] gpio_ts;
  logic [WIDTH-1:0] gpio_ps;
  logic             irq;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  gpio_ctrl #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .wdata   (wdata),
    .we      (we),
    .re      (re),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .err     (err),
    .gpio_dr (gpio_dr),
    .gpio_ts (gpio_ts),
    .gpio_ps (gpio_ps),
    .irq     (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a);
    addr = a;
    re   = 1'b1;
    tick();
    re   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset   = 1'b1;
    we      = 1'b0;
    re      = 1'b0;
    addr    = '0;
    wdata   = '0;
    gpio_ps = 16'hFFFF;
    repeat (3) tick();

    chk("reset_dr", 32'(gpio_dr), 32'h0);
    chk("reset_ts", 32'(gpio_ts), 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_rvalid", 32'(rvalid), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);

    // Pins held high through release; rising polarity armed straight away.
    reset = 1'b0;
    wr(ADDR_POL, 32'h0000_FFFF);
    chk("pol_wr_err", 32'(err), 32'h0);
    repeat (6) tick();
    rd(ADDR_IS);
    chk("is_static_high", rdata, 32'h0);

    wr(ADDR_DR, 32'h0000_00A5);
    chk("dr_a5", 32'(gpio_dr), 32'h0000_00A5);
    chk("dr_wr_err", 32'(err), 32'h0);
    wr(ADDR_TS, 32'h0000_00FF);
    chk("ts_ff", 32'(gpio_ts), 32'h0000_00FF);

    wr(ADDR_DR, 32'hABCD_5A5A);
    chk("dr_upper_ignored", 32'(gpio_dr), 32'h0000_5A5A);
    rd(ADDR_DR);
    chk("rd_dr", rdata, 32'h0000_5A5A);
    chk("rd_dr_rvalid", 32'(rvalid), 32'h1);
    tick();
    chk("rvalid_drop", 32'(rvalid), 32'h0);
    chk("rdata_hold", rdata, 32'h0000_5A5A);

    gpio_ps = 16'h1234;
    repeat (3) tick();
    rd(ADDR_PS);
    chk("rd_ps", rdata, 32'h0000_1234);
    chk("rd_ps_rvalid", 32'(rvalid), 32'h1);

    // Simultaneous write and read returns the pre-write value.
    addr  = ADDR_DR;
    wdata = 32'h0000_1111;
    we    = 1'b1;
    re    = 1'b1;
    tick();
    we    = 1'b0;
    re    = 1'b0;
    chk("rw_prewrite", rdata, 32'h0000_5A5A);
    chk("rw_dr_new", 32'(gpio_dr), 32'h0000_1111);

    rd(5'h18);
    chk("unmapped_rd_err", 32'(err), 32'h1);
    chk("unmapped_rd_data", rdata, 32'h0);
    chk("unmapped_rd_dr", 32'(gpio_dr), 32'h0000_1111);
    tick();
    chk("err_drop", 32'(err), 32'h0);

    wr(ADDR_PS, 32'h0000_FFFF);
    chk("ps_wr_err", 32'(err), 32'h1);
    rd(ADDR_PS);
    chk("ps_after_wr", rdata, 32'h0000_1234);
    wr(5'h1C, 32'h0000_0000);
    chk("unmapped_wr_err", 32'(err), 32'h1);
    chk("unmapped_wr_dr", 32'(gpio_dr), 32'h0000_1111);
    chk("unmapped_wr_ts", 32'(gpio_ts), 32'h0000_00FF);

    rd(5'h05);
    chk("addr_low_ignored", rdata, 32'h0000_00FF);

`ifdef GPIO_CTRL_IRQ_EN
    wr(ADDR_IE, 32'h0000_0001);
    wr(ADDR_POL, 32'h0000_0001);
    repeat (4) tick();
    gpio_ps = 16'h1235;
    n = 0;
    while (irq !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("irq_rise", 32'(irq), 32'h1);
    chk("irq_latency", 32'(n <= SYNC_STAGES + 2), 32'h1);
    rd(ADDR_IS);
    chk("is_bit0", rdata, 32'h0000_0001);
    wr(ADDR_IS, 32'h0000_0001);
    tick();
    chk("irq_cleared", 32'(irq), 32'h0);
    rd(ADDR_IS);
    chk("is_cleared", rdata, 32'h0);

    // W1C lands on the same edge that records a new rise.
    gpio_ps = 16'h1234;
    repeat (4) tick();
    gpio_ps = 16'h1235;
    tick();
    tick();
    wr(ADDR_IS, 32'h0000_0001);
    rd(ADDR_IS);
    chk("is_set_wins", rdata, 32'h0000_0001);

    wr(ADDR_IE, 32'h0000_0000);
    tick();
    chk("irq_masked", 32'(irq), 32'h0);
    rd(ADDR_IS);
    chk("is_kept_masked", rdata, 32'h0000_0001);
    wr(ADDR_IS, 32'h0000_0001);
    rd(ADDR_IS);
    chk("is_final_clear", rdata, 32'h0);
`else
    wr(ADDR_IE, 32'h0000_0001);
    chk("ie_wr_no_err", 32'(err), 32'h0);
    rd(ADDR_IE);
    chk("ie_reads_zero", rdata, 32'h0);
    gpio_ps = 16'h1235;
    repeat (5) tick();
    chk("irq_tied_low", 32'(irq), 32'h0);
    rd(ADDR_IS);
    chk("is_reads_zero", rdata, 32'h0);
`endif

    // Reset asserted while a read is in flight.
    addr  = ADDR_DR;
    re    = 1'b1;
    #2;
    reset = 1'b1;
    tick();
    re    = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("rst_mid_rvalid", 32'(rvalid), 32'h0);
    chk("rst_mid_err", 32'(err), 32'h0);
    tick();
    chk("rst_mid_rvalid2", 32'(rvalid), 32'h0);
    chk("rst_mid_dr", 32'(gpio_dr), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
